id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-Execute pipeline register of the pipelined CPU. It captures the Decode-stage control bundle and operands on each clock and presents them to the Execute stage. Those consumers are the condition/flag logic (CondE, FlagWriteE), the ALU, the hazard unit and the E/M register. It adds a per-entry valid bit, stall/flush control with fixed priority, and a saturating bubble counter for performance measurement.

## Interface

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 4, register-address width
- CNT_W, 16, bubble-counter width

Ports:
- CLK  in  1  clock, rising-edge
- Reset  in  1  asynchronous, active-low reset
- StallE  in  1  hold current E contents
- FlushE  in  1  replace E contents with a bubble
- CntClr  in  1  synchronous clear of BubbleCnt
- ValidD  in  1  D-stage holds a real instruction
- RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, PCSrcD  in  1 each  D-stage control
- ALUControlD  in  2  ALU operation
- FlagWriteD  in  2  flag-group write enables ([1]=NZ, [0]=CV)
- CondD  in  4  condition field
- RD1D, RD2D, ExtImmD  in  DATA_W each  operands, immediate
- WA3D, RA1D, RA2D  in  REG_AW each  destination and source register numbers
- ValidE  out  1  E-stage entry valid
- RegWriteE, MemWriteE, BranchE, PCSrcE  out  1 each  control, gated by ValidE
- FlagWriteE  out  2  gated by ValidE
- MemtoRegE, ALUSrcE  out  1 each  ungated
- ALUControlE  out  2  ungated
- CondE  out  4  ungated
- RD1E, RD2E, ExtImmE  out  DATA_W  registered operands
- WA3E, RA1E, RA2E  out  REG_AW  registered register numbers
- BubbleCnt  out  CNT_W  saturating count of cycles with ValidE=0

## Operation

- Per-edge update priority: Reset (async) > FlushE > StallE > load.
- Reset asserted (low):
  - ValidE=0.
  - All control and data registers go to 0.
  - BubbleCnt=0.
  - All outputs read 0.
- FlushE=1 (regardless of StallE):
  - ValidE<=0.
  - Control registers <=0.
  - Data/register-number fields hold their previous values.
- StallE=1, FlushE=0: every register holds, including ValidE.
- Otherwise (load):
  - ValidE<=ValidD.
  - Every field <= its D counterpart.
  - This applies even when ValidD=0. Control fields are then still loaded, and the output gating suppresses them.
- Gating:
  - RegWriteE, MemWriteE, BranchE, PCSrcE, FlagWriteE = stored value AND ValidE.
  - These state-changing signals can therefore never assert for an invalid entry.
- BubbleCnt, evaluated each edge after Reset:
  - CntClr=1 → 0.
  - Else if ValidE=0 (pre-edge value) and BubbleCnt≠all-ones → increment by 1.
  - Else hold.
  - Saturates at 2^CNT_W−1 with no wrap.
  - A stalled invalid entry counts every cycle.
- Simultaneous CntClr with an invalid entry: the clear wins and the count is 0 after the edge.

## Timing

- Latency: exactly 1 cycle, D inputs at edge n appear on E outputs after edge n.
- All outputs are register outputs or a register ANDed with ValidE; there is no combinational path from any D input.
- StallE/FlushE take effect at the same edge they are sampled high.
- Reset deassertion is not synchronised here; the top level provides a synchronised deassert.
- Reset mid-stall or mid-flush: the async clear dominates immediately, and the first post-reset edge follows normal priority.

## Structure

- cpu_pkg (shared) holds:
  - typedef ctrl_e_t: packed struct of RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, PCSrc, ALUControl[1:0], FlagWrite[1:0], Cond[3:0]. The same type is reused by the E/M register.
  - Localparam CTRL_W.
- Sub-module flopenrc #(WIDTH):
  - Async active-low reset, enable, synchronous clear.
  - Instantiated twice: control bundle plus ValidE (clear=FlushE, enable=~StallE|FlushE), and data fields (clear tied 0, enable=~StallE&~FlushE).
- The counter is inline.

## Test plan

- Load: Reset high, ValidD=1, RegWriteD=1, CondD=4'hE, RD1D=32'h0000_00AA, WA3D=4'd3 → the next edge gives ValidE=1, RegWriteE=1, CondE=4'hE, RD1E=32'hAA, WA3E=3.
- Stall: load FlagWriteD=2'b11, then StallE=1 for 3 cycles while D inputs change → E outputs stay unchanged for 3 cycles and BubbleCnt stays constant.
- Flush over stall: valid entry present, StallE=1 and FlushE=1 together → the next edge gives ValidE=0, RegWriteE=MemWriteE=0, FlagWriteE=2'b00, CondE=0, and RD1E retains its old value.
- Invalid gating: ValidD=0 with MemWriteD=1, PCSrcD=1 → the next edge gives MemWriteE=0, PCSrcE=0, and BubbleCnt increments by 1 on the following edge.
- Counter: CNT_W=4 with ValidD=0 held for 20 cycles → BubbleCnt saturates at 15; pulsing CntClr gives 0 at the next edge, resuming count after.
- Async reset: drive Reset low between edges during a stalled valid entry → all outputs go to 0 immediately without a clock edge, and stay 0 until the first edge after release.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: Execute-stage control bundle type shared by the D/E and E/M registers.
package id_ex_stage_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       pc_src;
    logic [1:0] alu_control;
    logic [1:0] flag_write;
    logic [3:0] cond;
  } ctrl_e_t;
  localparam int CTRL_W = $bits(ctrl_e_t);
  // Masks every state-changing control so an invalid entry can never commit anything.
  function automatic ctrl_e_t gate_ctrl(input ctrl_e_t c, input logic v);
    gate_ctrl = c;
    gate_ctrl.reg_write  = c.reg_write & v;
    gate_ctrl.mem_write  = c.mem_write & v;
    gate_ctrl.branch     = c.branch & v;
    gate_ctrl.pc_src     = c.pc_src & v;
    gate_ctrl.flag_write = c.flag_write & {2{v}};
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: Decode-side inputs, stall/flush control and Execute-side outputs of the D/E register.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              StallE, FlushE, CntClr, ValidD;
  logic              RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, PCSrcD;
  logic [1:0]        ALUControlD, FlagWriteD;
  logic [3:0]        CondD;
  logic [DATA_W-1:0] RD1D, RD2D, ExtImmD;
  logic [REG_AW-1:0] WA3D, RA1D, RA2D;
  logic              ValidE;
  logic              RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, PCSrcE;
  logic [1:0]        ALUControlE, FlagWriteE;
  logic [3:0]        CondE;
  logic [DATA_W-1:0] RD1E, RD2E, ExtImmE;
  logic [REG_AW-1:0] WA3E, RA1E, RA2E;
  logic [CNT_W-1:0]  BubbleCnt;
  modport master (
    output StallE, FlushE, CntClr, ValidD, RegWriteD, MemtoRegD, MemWriteD, BranchD,
           ALUSrcD, PCSrcD, ALUControlD, FlagWriteD, CondD, RD1D, RD2D, ExtImmD,
           WA3D, RA1D, RA2D,
    input  ValidE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, PCSrcE,
           ALUControlE, FlagWriteE, CondE, RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E,
           BubbleCnt
  );
  modport slave (
    input  StallE, FlushE, CntClr, ValidD, RegWriteD, MemtoRegD, MemWriteD, BranchD,
           ALUSrcD, PCSrcD, ALUControlD, FlagWriteD, CondD, RD1D, RD2D, ExtImmD,
           WA3D, RA1D, RA2D,
    output ValidE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, PCSrcE,
           ALUControlE, FlagWriteE, CondE, RD1E, RD2E, ExtImmE, WA3E, RA1E, RA2E,
           BubbleCnt
  );
endinterface

// File: rtl/id_ex_stage_flopenrc.sv
// id_ex_stage_flopenrc: register with async active-low reset, enable and synchronous clear.
module id_ex_stage_flopenrc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: Decode-to-Execute pipeline register with valid bit, flush-over-stall priority
// and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input logic          CLK,
  input logic          Reset,
  id_ex_stage_if.slave bus
);
  localparam int DW = 3*DATA_W + 3*REG_AW;
  ctrl_e_t          ctrl_d, ctrl_q, ctrl_g;
  logic             valid_q;
  logic [CTRL_W:0]  cv_q;
  logic [DW-1:0]    data_q;
  logic [CNT_W-1:0] cnt;
  assign ctrl_d = '{reg_write: bus.RegWriteD, mem_to_reg: bus.MemtoRegD, mem_write: bus.MemWriteD,
                    branch: bus.BranchD, alu_src: bus.ALUSrcD, pc_src: bus.PCSrcD,
                    alu_control: bus.ALUControlD, flag_write: bus.FlagWriteD, cond: bus.CondD};
  // Flush must reach the control flops even while stalled, so it also forces the enable.
  id_ex_stage_flopenrc #(.WIDTH(CTRL_W+1)) u_ctrl (
    .clk(CLK), .rst_n(Reset), .en(~bus.StallE | bus.FlushE), .clr(bus.FlushE),
    .d({bus.ValidD, ctrl_d}), .q(cv_q)
  );
  assign {valid_q, ctrl_q} = cv_q;
  // Operands keep their old values on flush; only control is cleared.
  id_ex_stage_flopenrc #(.WIDTH(DW)) u_data (
    .clk(CLK), .rst_n(Reset), .en(~bus.StallE & ~bus.FlushE), .clr(1'b0),
    .d({bus.RD1D, bus.RD2D, bus.ExtImmD, bus.WA3D, bus.RA1D, bus.RA2D}), .q(data_q)
  );
  assign {bus.RD1E, bus.RD2E, bus.ExtImmE, bus.WA3E, bus.RA1E, bus.RA2E} = data_q;
  assign ctrl_g          = gate_ctrl(ctrl_q, valid_q);
  assign bus.ValidE      = valid_q;
  assign bus.RegWriteE   = ctrl_g.reg_write;
  assign bus.MemWriteE   = ctrl_g.mem_write;
  assign bus.BranchE     = ctrl_g.branch;
  assign bus.PCSrcE      = ctrl_g.pc_src;
  assign bus.FlagWriteE  = ctrl_g.flag_write;
  assign bus.MemtoRegE   = ctrl_g.mem_to_reg;
  assign bus.ALUSrcE     = ctrl_g.alu_src;
  assign bus.ALUControlE = ctrl_g.alu_control;
  assign bus.CondE       = ctrl_g.cond;
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) cnt <= '0;
    else if (bus.CntClr) cnt <= '0;
    else if (!valid_q && cnt != '1) cnt <= cnt + CNT_W'(1);
  assign bus.BubbleCnt = cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for the D/E register; a behavioural model queues the
// expected E-side view at each edge and every test pops and compares it after the edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  typedef struct packed {
    logic        valid;
    logic        reg_write, mem_write, branch, pc_src;
    logic [1:0]  flag_write;
    logic        mem_to_reg, alu_src;
    logic [1:0]  alu_control;
    logic [3:0]  cond;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  wa3, ra1, ra2;
    logic [3:0]  cnt;
  } out_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;
  out_t        sb[$];
  out_t        e, a, snap;
  logic        m_valid;
  ctrl_e_t     m_ctrl;
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [3:0]  m_wa3, m_ra1, m_ra2, m_cnt;
  logic [3:0]  pre;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(4), .CNT_W(4)) bus ();
  id_ex_stage #(.DATA_W(32), .REG_AW(4), .CNT_W(4)) dut (.CLK(clk), .Reset(reset_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic out_t dut_out();
    return {bus.ValidE, bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.PCSrcE, bus.FlagWriteE,
            bus.MemtoRegE, bus.ALUSrcE, bus.ALUControlE, bus.CondE, bus.RD1E, bus.RD2E,
            bus.ExtImmE, bus.WA3E, bus.RA1E, bus.RA2E, bus.BubbleCnt};
  endfunction

  function automatic out_t model_out();
    return {m_valid, m_ctrl.reg_write & m_valid, m_ctrl.mem_write & m_valid,
            m_ctrl.branch & m_valid, m_ctrl.pc_src & m_valid, m_ctrl.flag_write & {2{m_valid}},
            m_ctrl.mem_to_reg, m_ctrl.alu_src, m_ctrl.alu_control, m_ctrl.cond,
            m_rd1, m_rd2, m_imm, m_wa3, m_ra1, m_ra2, m_cnt};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
    m_wa3 = '0; m_ra1 = '0; m_ra2 = '0; m_cnt = '0;
  endtask

  task automatic model_edge();
    logic [3:0] nc;
    nc = bus.CntClr ? 4'd0 : (!m_valid && m_cnt != 4'hF) ? m_cnt + 4'd1 : m_cnt;
    if (bus.FlushE) begin
      m_valid = 1'b0;
      m_ctrl  = '0;
    end else if (!bus.StallE) begin
      m_valid = bus.ValidD;
      m_ctrl  = '{reg_write: bus.RegWriteD, mem_to_reg: bus.MemtoRegD, mem_write: bus.MemWriteD,
                  branch: bus.BranchD, alu_src: bus.ALUSrcD, pc_src: bus.PCSrcD,
                  alu_control: bus.ALUControlD, flag_write: bus.FlagWriteD, cond: bus.CondD};
      m_rd1 = bus.RD1D; m_rd2 = bus.RD2D; m_imm = bus.ExtImmD;
      m_wa3 = bus.WA3D; m_ra1 = bus.RA1D; m_ra2 = bus.RA2D;
    end
    m_cnt = nc;
  endtask

  task automatic tick();
    if (!reset_n) model_reset();
    else model_edge();
    sb.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    bus.StallE = 0; bus.FlushE = 0; bus.CntClr = 0; bus.ValidD = 0;
    bus.RegWriteD = 0; bus.MemtoRegD = 0; bus.MemWriteD = 0; bus.BranchD = 0;
    bus.ALUSrcD = 0; bus.PCSrcD = 0; bus.ALUControlD = 0; bus.FlagWriteD = 0; bus.CondD = 0;
    bus.RD1D = 0; bus.RD2D = 0; bus.ExtImmD = 0; bus.WA3D = 0; bus.RA1D = 0; bus.RA2D = 0;
  endtask

  task automatic rand_d();
    bus.ValidD = 1'($urandom); bus.RegWriteD = 1'($urandom); bus.MemtoRegD = 1'($urandom);
    bus.MemWriteD = 1'($urandom); bus.BranchD = 1'($urandom); bus.ALUSrcD = 1'($urandom);
    bus.PCSrcD = 1'($urandom); bus.ALUControlD = 2'($urandom); bus.FlagWriteD = 2'($urandom);
    bus.CondD = 4'($urandom); bus.RD1D = $urandom; bus.RD2D = $urandom; bus.ExtImmD = $urandom;
    bus.WA3D = 4'($urandom); bus.RA1D = 4'($urandom); bus.RA2D = 4'($urandom);
  endtask

  task automatic test_reset();
    clear_d();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    a = dut_out(); n_checks++;
    if (a !== '0) begin n_fail++; $display("FAIL reset_zero: got=%h exp=%h", a, out_t'(0)); end
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front(); a = dut_out(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL reset_hold: got=%h exp=%h", a, e); end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_load();
    clear_d();
    bus.ValidD = 1; bus.RegWriteD = 1; bus.CondD = 4'hE; bus.RD1D = 32'h0000_00AA; bus.WA3D = 4'd3;
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL load_sb: got=%h exp=%h", a, e); end
    n_checks++;
    if ({bus.ValidE, bus.RegWriteE, bus.CondE, bus.RD1E, bus.WA3E} !== {1'b1, 1'b1, 4'hE, 32'hAA, 4'd3}) begin
      n_fail++;
      $display("FAIL load_fields: got=%h exp=%h",
               {bus.ValidE, bus.RegWriteE, bus.CondE, bus.RD1E, bus.WA3E}, {1'b1, 1'b1, 4'hE, 32'hAA, 4'd3});
    end
  endtask

  task automatic test_stall();
    clear_d();
    bus.ValidD = 1; bus.FlagWriteD = 2'b11; bus.RegWriteD = 1; bus.CondD = 4'h9;
    bus.RD1D = 32'h1234_5678;
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL stall_load: got=%h exp=%h", a, e); end
    n_checks++;
    if (bus.FlagWriteE !== 2'b11) begin n_fail++; $display("FAIL stall_flagwrite: got=%b exp=11", bus.FlagWriteE); end
    snap = model_out();
    bus.StallE = 1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      tick();
      e = sb.pop_front(); a = dut_out(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL stall_sb: got=%h exp=%h", a, e); end
      n_checks++;
      if (a !== snap) begin n_fail++; $display("FAIL stall_hold: got=%h exp=%h", a, snap); end
    end
  endtask

  task automatic test_flush();
    bus.StallE = 1; bus.FlushE = 1;
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL flush_sb: got=%h exp=%h", a, e); end
    n_checks++;
    if ({bus.ValidE, bus.RegWriteE, bus.MemWriteE, bus.FlagWriteE, bus.CondE, bus.RD1E} !==
        {1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL flush_fields: got=%h exp=%h",
               {bus.ValidE, bus.RegWriteE, bus.MemWriteE, bus.FlagWriteE, bus.CondE, bus.RD1E},
               {1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 32'h1234_5678});
    end
  endtask

  task automatic test_invalid();
    clear_d();
    bus.MemWriteD = 1; bus.PCSrcD = 1; bus.BranchD = 1; bus.CondD = 4'h3;
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL invalid_sb: got=%h exp=%h", a, e); end
    n_checks++;
    if ({bus.MemWriteE, bus.PCSrcE} !== 2'b00) begin
      n_fail++; $display("FAIL invalid_gate: got=%b exp=00", {bus.MemWriteE, bus.PCSrcE});
    end
    pre = m_cnt;
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL invalid_sb2: got=%h exp=%h", a, e); end
    n_checks++;
    if (bus.BubbleCnt !== pre + 4'd1) begin
      n_fail++; $display("FAIL invalid_count: got=%0d exp=%0d", bus.BubbleCnt, pre + 4'd1);
    end
  endtask

  task automatic test_counter();
    clear_d();
    bus.CntClr = 1;
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e || bus.BubbleCnt !== 4'd0) begin n_fail++; $display("FAIL cnt_clear: got=%h exp=%h", a, e); end
    bus.CntClr = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      e = sb.pop_front(); a = dut_out(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL cnt_run: got=%h exp=%h", a, e); end
    end
    n_checks++;
    if (bus.BubbleCnt !== 4'd15) begin n_fail++; $display("FAIL cnt_saturate: got=%0d exp=15", bus.BubbleCnt); end
    bus.CntClr = 1;
    tick();
    void'(sb.pop_front()); n_checks++;
    if (bus.BubbleCnt !== 4'd0) begin n_fail++; $display("FAIL cnt_clr_wins: got=%0d exp=0", bus.BubbleCnt); end
    bus.CntClr = 0;
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e || bus.BubbleCnt !== 4'd1) begin n_fail++; $display("FAIL cnt_resume: got=%h exp=%h", a, e); end
  endtask

  task automatic test_async_reset();
    clear_d();
    bus.ValidD = 1; bus.RegWriteD = 1; bus.MemWriteD = 1; bus.CondD = 4'h7;
    bus.RD1D = 32'hDEAD_BEEF; bus.WA3D = 4'd9;
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL async_load: got=%h exp=%h", a, e); end
    bus.StallE = 1;
    rand_d();
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL async_stall: got=%h exp=%h", a, e); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    a = dut_out(); n_checks++;
    if (a !== '0) begin n_fail++; $display("FAIL async_zero: got=%h exp=%h", a, out_t'(0)); end
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL async_held: got=%h exp=%h", a, e); end
    reset_n = 1'b1;
    #1;
    a = dut_out(); n_checks++;
    if (a !== '0) begin n_fail++; $display("FAIL async_release: got=%h exp=%h", a, out_t'(0)); end
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL async_first_edge: got=%h exp=%h", a, e); end
    bus.StallE = 0;
    tick();
    e = sb.pop_front(); a = dut_out(); n_checks++;
    if (a !== e) begin n_fail++; $display("FAIL async_reload: got=%h exp=%h", a, e); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      rand_d();
      bus.StallE = ($urandom_range(0, 3) == 0);
      bus.FlushE = ($urandom_range(0, 5) == 0);
      bus.CntClr = ($urandom_range(0, 9) == 0);
      tick();
      e = sb.pop_front(); a = dut_out(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL random_%0d: got=%h exp=%h", i, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_invalid();
    test_counter();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
